// File: rtl/wrt_arb_ctrl_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversions
// used by both the write- and read-domain controllers.
package wrt_arb_ctrl_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 4;
  localparam int unsigned DEF_DATA_SIZE = 8;
  localparam int unsigned PTR_MAX_W     = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wrt_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority rotates past the last
// requester that actually completed a transfer (advance=1).
module wrt_arb_ctrl_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   cand;
  logic             found;

  // Search starts one past the last winner and wraps around all requesters
  always_comb begin
    gnt     = '0;
    gnt_idx = last_q;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IDX_W-1:0]] = 1'b1;
        gnt_idx              = cand[IDX_W-1:0];
      end
    end
    last_d = advance ? gnt_idx : last_q;
  end

  // Reset to the highest index so requester 0 has first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wrt_arb_ctrl.sv
// Async-FIFO write-domain controller: arbitrates requesters onto the write port, owns the
// binary/Gray write pointer and full flag. Optional almost-full flag under WRT_ALMOST_FULL_EN.
module wrt_arb_ctrl
  import wrt_arb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned AF_LEVEL  = 2
) (
  input  logic                           wrt_clk,
  input  logic                           wrt_rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic [ADDR_SIZE:0]             sync_rd_ptr,
  output logic                           wrt_en,
  output logic [ADDR_SIZE-1:0]           wrt_addr,
  output logic [DATA_SIZE-1:0]           wrt_data,
  output logic [ADDR_SIZE:0]             wrt_ptr,
  output logic                           wrt_full
`ifdef WRT_ALMOST_FULL_EN
  ,
  output logic                           wrt_afull
`endif
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   wbin_q, wbin_d;
  logic [PTR_W-1:0]   wrt_ptr_q, wrt_ptr_d;
  logic               full_q, full_d;
  logic [PTR_W-1:0]   full_cmp;

  wrt_arb_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (wrt_clk),
    .rst_n   (wrt_rst_n),
    .req     (req),
    .advance (wrt_en),
    .gnt     (arb_gnt)
  );

  // Grant is suppressed while full and while reset is held
  always_comb begin
    gnt      = (wrt_rst_n && !full_q) ? arb_gnt : '0;
    wrt_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        wrt_data = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign wrt_en   = |gnt;
  assign wrt_addr = wbin_q[ADDR_SIZE-1:0];
  assign wrt_ptr  = wrt_ptr_q;
  assign wrt_full = full_q;

  // Full compares the next Gray pointer with the read pointer, top two bits inverted
  always_comb begin
    wbin_d    = wrt_en ? (wbin_q + PTR_W'(1)) : wbin_q;
    wrt_ptr_d = PTR_W'(bin2gray(PTR_MAX_W'(wbin_d)));
    full_cmp  = {~sync_rd_ptr[ADDR_SIZE:ADDR_SIZE-1], sync_rd_ptr[ADDR_SIZE-2:0]};
    full_d    = (wrt_ptr_d == full_cmp);
  end

  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      wbin_q    <= '0;
      wrt_ptr_q <= '0;
      full_q    <= 1'b0;
    end else begin
      wbin_q    <= wbin_d;
      wrt_ptr_q <= wrt_ptr_d;
      full_q    <= full_d;
    end
  end

`ifdef WRT_ALMOST_FULL_EN
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] used;
  logic [PTR_W-1:0] free_ent;
  logic             afull_q, afull_d;

  always_comb begin
    rbin     = PTR_W'(gray2bin(PTR_MAX_W'(sync_rd_ptr)));
    used     = wbin_d - rbin;
    free_ent = PTR_W'(DEPTH) - used;
    afull_d  = (free_ent <= PTR_W'(AF_LEVEL));
  end

  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign wrt_afull = afull_q;
`endif

endmodule

// File: tb/tb_wrt_arb_ctrl.sv
// Self-checking bench for wrt_arb_ctrl (ADDR_SIZE=4, DATA_SIZE=8, NUM_REQ=2, AF_LEVEL=2).
module tb_wrt_arb_ctrl;

  logic        wrt_clk;
  logic        wrt_rst_n;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic [4:0]  sync_rd_ptr;
  logic        wrt_en;
  logic [3:0]  wrt_addr;
  logic [7:0]  wrt_data;
  logic [4:0]  wrt_ptr;
  logic        wrt_full;
`ifdef WRT_ALMOST_FULL_EN
  logic        wrt_afull;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] gnt;
    logic [3:0] addr;
    logic [7:0] data;
    logic       full;
    logic [4:0] ptr;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int   m_wbin;
  int   m_last;
  logic m_full;

  wrt_arb_ctrl #(
    .ADDR_SIZE (4),
    .DATA_SIZE (8),
    .NUM_REQ   (2),
    .AF_LEVEL  (2)
  ) dut (
    .wrt_clk     (wrt_clk),
    .wrt_rst_n   (wrt_rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .sync_rd_ptr (sync_rd_ptr),
    .wrt_en      (wrt_en),
    .wrt_addr    (wrt_addr),
    .wrt_data    (wrt_data),
    .wrt_ptr     (wrt_ptr),
    .wrt_full    (wrt_full)
`ifdef WRT_ALMOST_FULL_EN
    ,
    .wrt_afull   (wrt_afull)
`endif
  );

  initial wrt_clk = 1'b0;
  always #5 wrt_clk = ~wrt_clk;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int popcnt5(input logic [4:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_wbin = 0;
    m_last = 1;
    m_full = 1'b0;
  endtask

  // Drive one cycle of stimulus and push the outputs the model expects for it
  task automatic drive_cycle(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [4:0] rdg);
    exp_t e;
    int   gi;
    @(posedge wrt_clk);
    #1;
    req         = r;
    req_data    = {d1, d0};
    sync_rd_ptr = rdg;
    e.full = m_full;
    e.ptr  = gray5(m_wbin);
    e.addr = 4'(m_wbin);
    e.gnt  = 2'b00;
    gi     = 0;
    if (!m_full) begin
      for (int k = 1; k <= 2; k++) begin
        int idx;
        idx = (m_last + k) % 2;
        if (r[idx] && e.gnt == 2'b00) begin
          e.gnt[idx] = 1'b1;
          gi = idx;
        end
      end
    end
    e.data = e.gnt[0] ? d0 : (e.gnt[1] ? d1 : 8'h00);
    if (e.gnt != 2'b00) begin
      m_wbin = (m_wbin + 1) % 32;
      m_last = gi;
    end
    m_full = (gray5(m_wbin) == (rdg ^ 5'b11000));
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge wrt_clk);
    #7;
    wrt_rst_n   = 1'b0;
    req         = 2'b00;
    sync_rd_ptr = 5'b0;
    @(posedge wrt_clk);
    @(negedge wrt_clk);
    wrt_rst_n = 1'b1;
    model_reset();
  endtask

  // Scoreboard: compare each driven cycle mid-period, away from the active edge
  always @(negedge wrt_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt) begin
        errors++;
        $display("FAIL sb_gnt: got %b want %b", gnt, e.gnt);
      end
      checks++;
      if (wrt_en !== (e.gnt != 2'b00)) begin
        errors++;
        $display("FAIL sb_wrt_en: got %b want %b", wrt_en, (e.gnt != 2'b00));
      end
      checks++;
      if (wrt_data !== e.data) begin
        errors++;
        $display("FAIL sb_wrt_data: got %h want %h", wrt_data, e.data);
      end
      checks++;
      if (wrt_addr !== e.addr) begin
        errors++;
        $display("FAIL sb_wrt_addr: got %0d want %0d", wrt_addr, e.addr);
      end
      checks++;
      if (wrt_full !== e.full) begin
        errors++;
        $display("FAIL sb_wrt_full: got %b want %b", wrt_full, e.full);
      end
      checks++;
      if (wrt_ptr !== e.ptr) begin
        errors++;
        $display("FAIL sb_wrt_ptr: got %b want %b", wrt_ptr, e.ptr);
      end
    end
  end

  task automatic test_reset();
    // Power-on reset with both requesters active
    wrt_rst_n   = 1'b0;
    req         = 2'b11;
    req_data    = 16'hBBAA;
    sync_rd_ptr = 5'b0;
    #3;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    checks++;
    if (wrt_en !== 1'b0) begin errors++; $display("FAIL rst_wrt_en: got %b want 0", wrt_en); end
    checks++;
    if (wrt_data !== 8'h00) begin errors++; $display("FAIL rst_wrt_data: got %h want 00", wrt_data); end
    checks++;
    if (wrt_ptr !== 5'b0) begin errors++; $display("FAIL rst_wrt_ptr: got %b want 0", wrt_ptr); end
    checks++;
    if (wrt_full !== 1'b0) begin errors++; $display("FAIL rst_wrt_full: got %b want 0", wrt_full); end
    @(negedge wrt_clk);
    wrt_rst_n = 1'b1;
    req       = 2'b00;
    model_reset();

    // Reset asserted mid-grant
    drive_cycle(2'b01, 8'h11, 8'h00, 5'b0);
    drive_cycle(2'b01, 8'h22, 8'h00, 5'b0);
    @(posedge wrt_clk);
    #1;
    req      = 2'b01;
    req_data = 16'h0033;
    #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_pre_gnt: got %b want 01", gnt); end
    wrt_rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL midrst_gnt: got %b want 00", gnt); end
    checks++;
    if (wrt_ptr !== 5'b0) begin errors++; $display("FAIL midrst_ptr: got %b want 0", wrt_ptr); end
    checks++;
    if (wrt_full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b want 0", wrt_full); end
    @(posedge wrt_clk);
    @(negedge wrt_clk);
    wrt_rst_n = 1'b1;
    req       = 2'b00;
    model_reset();
    #1;
    checks++;
    if (wrt_addr !== 4'd0) begin errors++; $display("FAIL midrst_addr: got %0d want 0", wrt_addr); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) drive_cycle(2'b01, 8'(8'h40 + i), 8'h00, 5'b0);
    drive_cycle(2'b01, 8'h7E, 8'h00, 5'b0);
    drive_cycle(2'b01, 8'h7F, 8'h00, 5'b0);
    checks++;
    if (wrt_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", wrt_full); end
  endtask

  task automatic test_unfull();
    // Reader consumed one entry: Gray(1) = 00001
    drive_cycle(2'b01, 8'h90, 8'h00, 5'b00001);
    drive_cycle(2'b01, 8'h91, 8'h00, 5'b00001);
    drive_cycle(2'b01, 8'h92, 8'h00, 5'b00001);
    checks++;
    if (wrt_full !== 1'b1) begin errors++; $display("FAIL unfull_refull: got %b want 1", wrt_full); end
  endtask

  task automatic test_rr();
    do_reset();
    for (int i = 0; i < 8; i++) drive_cycle(2'b11, 8'(8'hA0 + i), 8'(8'hB0 + i), 5'b0);
    drive_cycle(2'b00, 8'h00, 8'h00, 5'b0);
    checks++;
    if (wrt_addr !== 4'd8) begin errors++; $display("FAIL rr_addr: got %0d want 8", wrt_addr); end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    logic       wrapped;
    int         changes;
    do_reset();
    prev    = 5'b0;
    wrapped = 1'b0;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(2'b10, 8'(8'hC0 + i), 8'(8'hD0 + i), (m_wbin < 2) ? 5'b0 : gray5(m_wbin - 2));
      if (wrt_ptr !== prev) begin
        changes++;
        checks++;
        if (popcnt5(wrt_ptr ^ prev) != 1) begin
          errors++;
          $display("FAIL wrap_gray_step: got %b from %b want single-bit change", wrt_ptr, prev);
        end
        if (prev == 5'b10000 && wrt_ptr == 5'b00000) wrapped = 1'b1;
      end
      prev = wrt_ptr;
    end
    checks++;
    if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_31_to_0: got %b want 1", wrapped); end
    checks++;
    if (changes != 39) begin errors++; $display("FAIL wrap_changes: got %0d want 39", changes); end
  endtask

  task automatic test_afull();
`ifdef WRT_ALMOST_FULL_EN
    do_reset();
    for (int i = 0; i < 14; i++) drive_cycle(2'b01, 8'(i), 8'h00, 5'b0);
    checks++;
    if (wrt_afull !== 1'b0) begin errors++; $display("FAIL afull_13: got %b want 0", wrt_afull); end
    drive_cycle(2'b00, 8'h00, 8'h00, 5'b0);
    checks++;
    if (wrt_afull !== 1'b1) begin errors++; $display("FAIL afull_14: got %b want 1", wrt_afull); end
    checks++;
    if (wrt_full !== 1'b0) begin errors++; $display("FAIL afull_full: got %b want 0", wrt_full); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_unfull();
    test_rr();
    test_wrap();
    test_afull();
    @(posedge wrt_clk);
    @(posedge wrt_clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
